// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller, ALUControl and datapath muxes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_ctrl_pkg;

    // FSM state encoding; values are visible on debug taps, so keep them fixed.
    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    // ALUOp codes consumed by ALUControl.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_FUNCT = 4'd2,
        ALU_AND   = 4'd3,
        ALU_LU    = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_ADDU  = 4'd6,
        ALU_SLTU  = 4'd7
    } aluop_e;

    // Opcodes (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // Funct codes (IR[5:0]) that change sequencing or operand routing.
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    // Datapath mux encodings.
    localparam logic [1:0] REGDST_RT       = 2'd0;
    localparam logic [1:0] REGDST_RD       = 2'd1;
    localparam logic [1:0] REGDST_RA       = 2'd2;
    localparam logic [1:0] MEMTOREG_ALUOUT = 2'd0;
    localparam logic [1:0] MEMTOREG_MDR    = 2'd1;
    localparam logic [1:0] MEMTOREG_PC     = 2'd2;
    localparam logic [1:0] SRCA_PC         = 2'd0;
    localparam logic [1:0] SRCA_RS         = 2'd1;
    localparam logic [1:0] SRCA_SHAMT      = 2'd2;
    localparam logic [1:0] SRCB_RT         = 2'd0;
    localparam logic [1:0] SRCB_FOUR       = 2'd1;
    localparam logic [1:0] SRCB_IMM        = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2    = 2'd3;
    localparam logic [1:0] PCSRC_ALU       = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'd1;
    localparam logic [1:0] PCSRC_JUMP      = 2'd2;
    localparam logic [1:0] PCSRC_RS        = 2'd3;

    // Instruction classes produced by ctrl_decode; the FSM only sees these.
    typedef enum logic [3:0] {
        CLS_RTYPE,
        CLS_SHIFT,
        CLS_JR,
        CLS_JALR,
        CLS_IARITH,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_J,
        CLS_JAL,
        CLS_ILLEGAL
    } iclass_e;

    // Decoded instruction: class plus the per-opcode EX controls of I-arith ops.
    typedef struct packed {
        iclass_e cls;
        aluop_e  imm_aluop;
        logic    imm_sext;
        logic    imm_lui;
    } dec_t;

    // Classes that finish in ID (2-cycle instructions).
    function automatic logic ends_in_id(input iclass_e c);
        return (c == CLS_J) || (c == CLS_JAL) || (c == CLS_JR) ||
               (c == CLS_JALR) || (c == CLS_ILLEGAL);
    endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Control bundle between the multi-cycle controller and the shared datapath.
// Latency: n/a (wires only).
// Backpressure: none; master drives controls every cycle, slave drives IR fields and Zero.
// Ports: OpCode/Funct/Zero from datapath; mux selects, write enables, ALUOp,
//        InstDone and RetireCnt from the controller.
interface multi_cycle_controller_if;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic        Zero;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  RegDst;
    logic [1:0]  MemtoReg;
    logic        ExtOp;
    logic        LuiOp;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUOp;
    logic [1:0]  PCSource;
    logic        InstDone;
    logic [31:0] RetireCnt;

    modport master (
        input  OpCode, Funct, Zero,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               RegDst, MemtoReg, ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               InstDone, RetireCnt
    );

    modport slave (
        output OpCode, Funct, Zero,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               RegDst, MemtoReg, ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               InstDone, RetireCnt
    );
endinterface

// File: rtl/multi_cycle_controller_decode.sv
// Classifies IR OpCode/Funct into an instruction class plus I-arith EX controls.
// Latency: combinational.
// Backpressure: none.
// Ports: op_code, funct in; dec (class, imm ALUOp, sign-extend, lui) out.
module ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec.cls       = CLS_ILLEGAL;
        dec.imm_aluop = ALU_ADD;
        dec.imm_sext  = 1'b1;
        dec.imm_lui   = 1'b0;
        case (op_code)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA: dec.cls = CLS_SHIFT;
                    FN_JR:                  dec.cls = CLS_JR;
                    FN_JALR:                dec.cls = CLS_JALR;
                    default:                dec.cls = CLS_RTYPE;
                endcase
            end
            OP_J:     dec.cls = CLS_J;
            OP_JAL:   dec.cls = CLS_JAL;
            OP_BEQ:   dec.cls = CLS_BEQ;
            OP_LW:    dec.cls = CLS_LOAD;
            OP_SW:    dec.cls = CLS_STORE;
            OP_ADDI: begin
                dec.cls       = CLS_IARITH;
                dec.imm_aluop = ALU_ADD;
            end
            OP_ADDIU: begin
                dec.cls       = CLS_IARITH;
                dec.imm_aluop = ALU_ADDU;
            end
            OP_SLTI: begin
                dec.cls       = CLS_IARITH;
                dec.imm_aluop = ALU_SLT;
            end
            OP_SLTIU: begin
                dec.cls       = CLS_IARITH;
                dec.imm_aluop = ALU_SLTU;
            end
            OP_ANDI: begin
                // Logical immediates are zero-extended.
                dec.cls       = CLS_IARITH;
                dec.imm_aluop = ALU_AND;
                dec.imm_sext  = 1'b0;
            end
            OP_LUI: begin
                // Immediate goes through the <<16 path; extension is irrelevant.
                dec.cls       = CLS_IARITH;
                dec.imm_aluop = ALU_LU;
                dec.imm_sext  = 1'b0;
                dec.imm_lui   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Main IF/ID/EX/MEM/WB control FSM of the multi-cycle MIPS CPU, with retire counter.
// Latency: controls combinational from state/IR; 2-5 cycles per instruction; RetireCnt +1 on the closing edge.
// Backpressure: none; advances one state per clock, reset aborts the current instruction.
// Ports: clk, reset (async, active-high); bus = controller side of multi_cycle_controller_if.
module multi_cycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    multi_cycle_controller_if.master   bus
);

    state_e      state_q, state_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    dec_t        dec;

    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source;
    logic        ext_op, lui_op, inst_done;
    aluop_e      alu_op;

    // Zero is consumed by the datapath's PCWriteCond gate, not by the FSM.
    logic        zero_unused;
    assign zero_unused = bus.Zero;

    ctrl_decode u_decode (
        .op_code (bus.OpCode),
        .funct   (bus.Funct),
        .dec     (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IF;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Wraps naturally at 2^32.
    assign retire_cnt_d = inst_done ? retire_cnt_q + 32'd1 : retire_cnt_q;

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = REGDST_RT;
        mem_to_reg    = MEMTOREG_ALUOUT;
        ext_op        = 1'b0;
        lui_op        = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        inst_done     = 1'b0;

        case (state_q)
            ST_IF: begin
                // Fetch and PC+4 in the same cycle.
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = ST_ID;
            end
            ST_ID: begin
                // Branch target precomputed into ALUOut for every instruction.
                alu_src_b = SRCB_IMM_SH2;
                ext_op    = 1'b1;
                state_d   = ST_EX;
                case (dec.cls)
                    CLS_J: begin
                        pc_write  = 1'b1;
                        pc_source = PCSRC_JUMP;
                    end
                    CLS_JAL: begin
                        pc_write   = 1'b1;
                        pc_source  = PCSRC_JUMP;
                        reg_write  = 1'b1;
                        reg_dst    = REGDST_RA;
                        mem_to_reg = MEMTOREG_PC;
                    end
                    CLS_JR: begin
                        pc_write  = 1'b1;
                        pc_source = PCSRC_RS;
                    end
                    CLS_JALR: begin
                        pc_write   = 1'b1;
                        pc_source  = PCSRC_RS;
                        reg_write  = 1'b1;
                        reg_dst    = REGDST_RD;
                        mem_to_reg = MEMTOREG_PC;
                    end
                    default: ;
                endcase
                // Jumps and unsupported opcodes (retired as NOPs) end here.
                if (ends_in_id(dec.cls)) begin
                    inst_done = 1'b1;
                    state_d   = ST_IF;
                end
            end
            ST_EX: begin
                case (dec.cls)
                    CLS_RTYPE, CLS_SHIFT: begin
                        alu_src_a = (dec.cls == CLS_SHIFT) ? SRCA_SHAMT : SRCA_RS;
                        alu_src_b = SRCB_RT;
                        alu_op    = ALU_FUNCT;
                        state_d   = ST_WB;
                    end
                    CLS_IARITH: begin
                        alu_src_a = SRCA_RS;
                        alu_src_b = SRCB_IMM;
                        alu_op    = dec.imm_aluop;
                        ext_op    = dec.imm_sext;
                        lui_op    = dec.imm_lui;
                        state_d   = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_a = SRCA_RS;
                        alu_src_b = SRCB_IMM;
                        ext_op    = 1'b1;
                        alu_op    = ALU_ADD;
                        state_d   = ST_MEM;
                    end
                    CLS_BEQ: begin
                        alu_src_a     = SRCA_RS;
                        alu_src_b     = SRCB_RT;
                        alu_op        = ALU_SUB;
                        pc_write_cond = 1'b1;
                        pc_source     = PCSRC_ALUOUT;
                        inst_done     = 1'b1;
                        state_d       = ST_IF;
                    end
                    default: begin
                        // Only reachable if IR changed under us; retire and refetch.
                        inst_done = 1'b1;
                        state_d   = ST_IF;
                    end
                endcase
            end
            ST_MEM: begin
                i_or_d = 1'b1;
                if (dec.cls == CLS_LOAD) begin
                    mem_read = 1'b1;
                    state_d  = ST_WB;
                end else begin
                    mem_write = (dec.cls == CLS_STORE);
                    inst_done = 1'b1;
                    state_d   = ST_IF;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                inst_done = 1'b1;
                state_d   = ST_IF;
                if (dec.cls == CLS_RTYPE || dec.cls == CLS_SHIFT) begin
                    reg_dst = REGDST_RD;
                end
                if (dec.cls == CLS_LOAD) begin
                    mem_to_reg = MEMTOREG_MDR;
                end
            end
            default: state_d = ST_IF;
        endcase
    end

    // While reset is high the FSM sits in IF, so every output is forced to
    // zero here to keep fetch side effects off the bus.
    assign bus.PCWrite     = pc_write      & ~reset;
    assign bus.PCWriteCond = pc_write_cond & ~reset;
    assign bus.IorD        = i_or_d        & ~reset;
    assign bus.MemRead     = mem_read      & ~reset;
    assign bus.MemWrite    = mem_write     & ~reset;
    assign bus.IRWrite     = ir_write      & ~reset;
    assign bus.RegWrite    = reg_write     & ~reset;
    assign bus.RegDst      = reset ? 2'd0 : reg_dst;
    assign bus.MemtoReg    = reset ? 2'd0 : mem_to_reg;
    assign bus.ExtOp       = ext_op        & ~reset;
    assign bus.LuiOp       = lui_op        & ~reset;
    assign bus.ALUSrcA     = reset ? 2'd0 : alu_src_a;
    assign bus.ALUSrcB     = reset ? 2'd0 : alu_src_b;
    assign bus.ALUOp       = reset ? 4'd0 : alu_op;
    assign bus.PCSource    = reset ? 2'd0 : pc_source;
    assign bus.InstDone    = inst_done     & ~reset;
    assign bus.RetireCnt   = retire_cnt_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: directed and random instruction streams vs a behavioural model.
// Latency: model tracks the cycle index within each instruction and the retired count.
// Backpressure: n/a.
module tb_multi_cycle_controller;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, rw;
        logic [1:0] regdst, m2r;
        logic       ext, lui;
        logic [1:0] srca, srcb;
        logic [3:0] aluop;
        logic [1:0] pcs;
        logic       done;
    } ctl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multi_cycle_controller_if bus ();

    multi_cycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_chk  = 0;

    logic [5:0]  m_op = 6'h00;
    logic [5:0]  m_funct = 6'h00;
    int          m_idx = 0;
    logic [31:0] m_cnt = 32'd0;
    ctl_t        snap [0:4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    endtask

    function automatic ctl_t sample();
        ctl_t s;
        s = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
             bus.IRWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ExtOp, bus.LuiOp,
             bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.InstDone};
        return s;
    endfunction

    // ---------------- behavioural model ----------------
    function automatic logic is_iarith(input logic [5:0] op);
        return op == 6'h08 || op == 6'h09 || op == 6'h0a || op == 6'h0b ||
               op == 6'h0c || op == 6'h0f;
    endfunction

    function automatic int model_cpi(input logic [5:0] op, input logic [5:0] f);
        if (op == 6'h00) return (f == 6'h08 || f == 6'h09) ? 2 : 4;
        if (op == 6'h04) return 3;
        if (op == 6'h23) return 5;
        if (op == 6'h2b || is_iarith(op)) return 4;
        return 2;  // j, jal, unsupported
    endfunction

    // Controls expected on cycle idx (0-based) of instruction op/f.
    function automatic ctl_t model_ctl(input logic [5:0] op, input logic [5:0] f,
                                       input int idx, input logic rst);
        ctl_t e;
        int   ph;
        logic rtype, mem_op;
        e = '0;
        if (rst) return e;
        rtype  = (op == 6'h00) && (f != 6'h08) && (f != 6'h09);
        mem_op = (op == 6'h23) || (op == 6'h2b);
        ph = (idx <= 2) ? idx : (mem_op && idx == 3) ? 3 : 4;
        case (ph)
            0: begin
                e.pcw = 1; e.mrd = 1; e.irw = 1; e.srcb = 1;
            end
            1: begin
                e.srcb = 3; e.ext = 1;
                if (op == 6'h02 || op == 6'h03) begin e.pcw = 1; e.pcs = 2; end
                if (op == 6'h03) begin e.rw = 1; e.regdst = 2; e.m2r = 2; end
                if (op == 6'h00 && (f == 6'h08 || f == 6'h09)) begin e.pcw = 1; e.pcs = 3; end
                if (op == 6'h00 && f == 6'h09) begin e.rw = 1; e.regdst = 1; e.m2r = 2; end
                e.done = (model_cpi(op, f) == 2);
            end
            2: begin
                if (rtype) begin
                    e.srca = (f == 6'h00 || f == 6'h02 || f == 6'h03) ? 2'd2 : 2'd1;
                    e.aluop = 2;
                end else if (is_iarith(op)) begin
                    e.srca = 1; e.srcb = 2;
                    e.ext = !(op == 6'h0c || op == 6'h0f);
                    e.lui = (op == 6'h0f);
                    case (op)
                        6'h09:   e.aluop = 6;
                        6'h0a:   e.aluop = 5;
                        6'h0b:   e.aluop = 7;
                        6'h0c:   e.aluop = 3;
                        6'h0f:   e.aluop = 4;
                        default: e.aluop = 0;
                    endcase
                end else if (mem_op) begin
                    e.srca = 1; e.srcb = 2; e.ext = 1;
                end else begin  // beq
                    e.srca = 1; e.aluop = 1; e.pcwc = 1; e.pcs = 1; e.done = 1;
                end
            end
            3: begin
                e.iord = 1;
                if (op == 6'h23) e.mrd = 1;
                else begin e.mwr = 1; e.done = 1; end
            end
            default: begin
                e.rw = 1; e.done = 1;
                if (rtype) e.regdst = 1;
                if (op == 6'h23) e.m2r = 1;
            end
        endcase
        return e;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("ctl", 32'(sample()), 32'(model_ctl(m_op, m_funct, m_idx, reset)));
        check("retire_cnt", bus.RetireCnt, m_cnt);
    end

    // Runs one instruction; OpCode is garbage during IF (IR not yet loaded).
    // If abort_at >= 0, reset is raised on that cycle and the instruction is abandoned.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                             input logic zval, input logic rand_zero, input int abort_at);
        int n;
        n = model_cpi(op, f);
        m_op = op; m_funct = f; m_idx = 0;
        bus.OpCode = 6'($urandom);
        bus.Funct  = 6'($urandom);
        bus.Zero   = zval;
        for (int k = 0; k < n; k++) begin
            @(negedge clk); #1;
            snap[k] = sample();
            if (k == abort_at) begin
                reset = 1'b1; m_cnt = 32'd0; m_idx = 0;
                #1;
                check("abort_memwrite", {31'd0, bus.MemWrite}, 32'd0);
                check("abort_cnt", bus.RetireCnt, 32'd0);
                @(posedge clk); @(negedge clk); #1;
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (k == 0) begin bus.OpCode = op; bus.Funct = f; end
            if (rand_zero) bus.Zero = 1'($urandom);
            if (k == n - 1) begin m_cnt = m_cnt + 32'd1; m_idx = 0; end
            else m_idx = m_idx + 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] ops [0:11];
        logic [5:0] fns [0:9];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23, 6'h2b};
        fns = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h24, 6'h2a};
        bus.OpCode = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0;

        // Reset state.
        @(negedge clk); #1;
        check("rst_cnt", bus.RetireCnt, 32'd0);
        check("rst_pcwrite", {31'd0, bus.PCWrite}, 32'd0);
        check("rst_irwrite", {31'd0, bus.IRWrite}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // add
        run_instr(6'h00, 6'h20, 1'b0, 1'b1, -1);
        check("add_ex_aluop", 32'(snap[2].aluop), 32'd2);
        check("add_ex_srca", 32'(snap[2].srca), 32'd1);
        check("add_wb_regwrite_regdst", {snap[3].rw, snap[3].regdst}, 32'b101);
        check("add_cnt", bus.RetireCnt, 32'd1);
        // lw
        run_instr(6'h23, 6'h11, 1'b0, 1'b1, -1);
        check("lw_mem_iord_mrd", {snap[3].iord, snap[3].mrd}, 32'b11);
        check("lw_wb_m2r", 32'(snap[4].m2r), 32'd1);
        // sw
        run_instr(6'h2b, 6'h05, 1'b0, 1'b1, -1);
        check("sw_mem_mwr_done", {snap[3].mwr, snap[3].done}, 32'b11);
        check("sw_no_regwrite", {snap[0].rw, snap[1].rw, snap[2].rw, snap[3].rw}, 32'd0);
        // beq, both Zero values
        run_instr(6'h04, 6'h00, 1'b1, 1'b0, -1);
        check("beq_z1_ex", {snap[2].pcwc, snap[2].pcs, snap[2].aluop, snap[2].done}, 32'b1_01_0001_1);
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, -1);
        check("beq_z0_ex", {snap[2].pcwc, snap[2].pcs, snap[2].aluop, snap[2].done}, 32'b1_01_0001_1);
        check("beq_cnt", bus.RetireCnt, 32'd5);
        // jal
        run_instr(6'h03, 6'h00, 1'b0, 1'b1, -1);
        check("jal_id", {snap[1].pcw, snap[1].pcs, snap[1].rw, snap[1].regdst,
                         snap[1].m2r, snap[1].done}, 32'b1_10_1_10_10_1);
        // sll, andi, sltiu, lui
        run_instr(6'h00, 6'h00, 1'b0, 1'b1, -1);
        check("sll_ex_srca", 32'(snap[2].srca), 32'd2);
        run_instr(6'h0c, 6'h3f, 1'b0, 1'b1, -1);
        check("andi_ex", {snap[2].ext, snap[2].aluop}, 32'b0_0011);
        run_instr(6'h0b, 6'h01, 1'b0, 1'b1, -1);
        check("sltiu_ex_aluop", 32'(snap[2].aluop), 32'd7);
        run_instr(6'h0f, 6'h00, 1'b0, 1'b1, -1);
        check("lui_ex", {snap[2].lui, snap[2].aluop}, 32'b1_0100);
        check("directed_cnt", bus.RetireCnt, 32'd10);

        // Random stream.
        for (int i = 0; i < 300; i++) begin
            op = (i % 13 == 12) ? 6'($urandom) : ops[$urandom_range(0, 11)];
            fn = (op == 6'h00 && $urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 9)]
                                                             : 6'($urandom);
            run_instr(op, fn, 1'b0, 1'b1, -1);
        end

        // Reset during MEM of sw, then an unsupported opcode.
        run_instr(6'h2b, 6'h00, 1'b0, 1'b1, 3);
        run_instr(6'h3f, 6'h00, 1'b0, 1'b1, -1);
        check("op3f_id_done", 32'(snap[1].done), 32'd1);
        check("op3f_no_writes", {snap[1].pcw, snap[1].pcwc, snap[1].mwr,
                                 snap[1].irw, snap[1].rw}, 32'd0);
        check("op3f_cnt", bus.RetireCnt, 32'd1);

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
